cart_mem_arbiter: RTL and testbench

- Sequences all accesses to the cartridge SDRAM port between two requesters: the HPS loader (ioctl byte writes during download) and the console ROM bus (byte reads).
- At the end of each download it derives the power-of-two bank mask used to mirror ROM reads.
- It holds a one-entry read cache so that repeated fetches of the same byte skip SDRAM.
- It sits between hps_io/system and the sdram controller.

---
 rtl/cart_mem_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_cart_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_mem_arbiter.sv
// rtl/cart_mem_arbiter.sv - cartridge SDRAM arbiter between HPS loader writes and console ROM reads
module cart_mem_arbiter #(
  parameter int AW = 22
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic           ioctl_download,
  input  logic           ioctl_wr,
  input  logic [24:0]    ioctl_addr,
  input  logic [7:0]     ioctl_dout,
  output logic           ioctl_wait,
  output logic           wr_overrun,
  input  logic           rom_rd,
  input  logic [AW-1:0]  rom_a,
  output logic [7:0]     rom_do,
  output logic           rom_valid,
  output logic [AW-15:0] cart_mask,
  output logic           cart_loaded,
  output logic [AW-1:0]  mem_addr,
  output logic [7:0]     mem_din,
  output logic           mem_we,
  output logic           mem_rd,
  input  logic [7:0]     mem_dout,
  input  logic           mem_ready
);

  localparam int BW = AW - 14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          wr_pend_q, wr_pend_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          rd_pend_q, rd_pend_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          cache_vld_q, cache_vld_d;
  logic [AW-1:0] cache_tag_q, cache_tag_d;
  logic [7:0]    cache_data_q, cache_data_d;
  logic [AW-1:0] max_addr_q, max_addr_d;
  logic          dl_q, dl_d;
  logic          mask_req_q, mask_req_d;

  logic          ioctl_wait_q, ioctl_wait_d;
  logic          wr_overrun_q, wr_overrun_d;
  logic [7:0]    rom_do_q, rom_do_d;
  logic          rom_valid_q, rom_valid_d;
  logic [BW-1:0] cart_mask_q, cart_mask_d;
  logic          cart_loaded_q, cart_loaded_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_din_q, mem_din_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_rd_q, mem_rd_d;

  logic          wr_clr;
  logic          dl_rise;
  logic          dl_fall;
  logic [BW-1:0] mask_smear;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^ioctl_addr[24:AW];

  always_comb begin
    state_d       = state_q;
    wr_pend_d     = wr_pend_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    rd_pend_d     = rd_pend_q;
    rd_addr_d     = rd_addr_q;
    cache_vld_d   = cache_vld_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;
    max_addr_d    = max_addr_q;
    dl_d          = ioctl_download;
    mask_req_d    = mask_req_q;
    ioctl_wait_d  = wr_pend_q;
    wr_overrun_d  = wr_overrun_q;
    rom_do_d      = rom_do_q;
    rom_valid_d   = 1'b0;
    cart_mask_d   = cart_mask_q;
    cart_loaded_d = cart_loaded_q;
    mem_addr_d    = mem_addr_q;
    mem_din_d     = mem_din_q;
    mem_we_d      = 1'b0;
    mem_rd_d      = 1'b0;

    wr_clr  = (state_q == S_WR) && mem_ready;
    dl_rise = ioctl_download && !dl_q;
    dl_fall = !ioctl_download && dl_q;

    // Smear the highest written bank downwards to get a 2^n-1 mirror mask.
    mask_smear = max_addr_q[AW-1:14];
    for (int i = BW - 2; i >= 0; i--) begin
      mask_smear[i] = mask_smear[i] | mask_smear[i + 1];
    end

    case (state_q)
      S_IDLE: begin
        if (wr_pend_q) begin
          mem_addr_d = wr_addr_q;
          mem_din_d  = wr_data_q;
          mem_we_d   = 1'b1;
          state_d    = S_WR;
        end else if (rd_pend_q && cache_vld_q && (cache_tag_q == rd_addr_q)) begin
          rom_do_d    = cache_data_q;
          rom_valid_d = 1'b1;
          rd_pend_d   = 1'b0;
        end else if (rd_pend_q) begin
          mem_addr_d = rd_addr_q;
          mem_rd_d   = 1'b1;
          rd_pend_d  = 1'b0;
          state_d    = S_RD;
        end
      end
      S_WR: begin
        if (mem_ready) begin
          wr_pend_d   = 1'b0;
          cache_vld_d = 1'b0;
          if (wr_addr_q > max_addr_q) begin
            max_addr_d = wr_addr_q;
          end
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        // mem_addr_q is held for the whole access, so it doubles as the cache tag.
        if (mem_ready) begin
          rom_do_d     = mem_dout;
          rom_valid_d  = 1'b1;
          cache_vld_d  = 1'b1;
          cache_tag_d  = mem_addr_q;
          cache_data_d = mem_dout;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ioctl_wr) begin
      if (!wr_pend_q || wr_clr) begin
        wr_addr_d = ioctl_addr[AW-1:0];
        wr_data_d = ioctl_dout;
        wr_pend_d = 1'b1;
      end else begin
        wr_overrun_d = 1'b1;
      end
    end

    if (rom_rd && !ioctl_download) begin
      rd_addr_d = {rom_a[AW-1:14] & cart_mask_q, rom_a[13:0]};
      rd_pend_d = 1'b1;
    end

    // The mask waits for the final loader write to land in max_addr.
    if (dl_fall) begin
      mask_req_d = 1'b1;
    end else if (mask_req_q && (state_q == S_IDLE) && !wr_pend_q) begin
      cart_mask_d   = mask_smear;
      cart_loaded_d = 1'b1;
      mask_req_d    = 1'b0;
    end

    if (dl_rise) begin
      max_addr_d    = '0;
      cart_loaded_d = 1'b0;
      wr_overrun_d  = 1'b0;
      cache_vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_pend_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      rd_pend_q     <= 1'b0;
      rd_addr_q     <= '0;
      cache_vld_q   <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
      max_addr_q    <= '0;
      dl_q          <= 1'b0;
      mask_req_q    <= 1'b0;
      ioctl_wait_q  <= 1'b0;
      wr_overrun_q  <= 1'b0;
      rom_do_q      <= '0;
      rom_valid_q   <= 1'b0;
      cart_mask_q   <= '1;
      cart_loaded_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      mem_we_q      <= 1'b0;
      mem_rd_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_pend_q     <= wr_pend_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      rd_pend_q     <= rd_pend_d;
      rd_addr_q     <= rd_addr_d;
      cache_vld_q   <= cache_vld_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
      max_addr_q    <= max_addr_d;
      dl_q          <= dl_d;
      mask_req_q    <= mask_req_d;
      ioctl_wait_q  <= ioctl_wait_d;
      wr_overrun_q  <= wr_overrun_d;
      rom_do_q      <= rom_do_d;
      rom_valid_q   <= rom_valid_d;
      cart_mask_q   <= cart_mask_d;
      cart_loaded_q <= cart_loaded_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      mem_we_q      <= mem_we_d;
      mem_rd_q      <= mem_rd_d;
    end
  end

  assign ioctl_wait  = ioctl_wait_q;
  assign wr_overrun  = wr_overrun_q;
  assign rom_do      = rom_do_q;
  assign rom_valid   = rom_valid_q;
  assign cart_mask   = cart_mask_q;
  assign cart_loaded = cart_loaded_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_we      = mem_we_q;
  assign mem_rd      = mem_rd_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// tb/tb_cart_mem_arbiter.sv - directed scoreboard bench for cart_mem_arbiter
module tb_cart_mem_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        wr_overrun;
  logic        rom_rd;
  logic [21:0] rom_a;
  logic [7:0]  rom_do;
  logic        rom_valid;
  logic [7:0]  cart_mask;
  logic        cart_loaded;
  logic [21:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        mem_rd;
  logic [7:0]  mem_dout;
  logic        mem_ready;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_memrd = 0;
  int n_memwe = 0;

  logic [7:0]  rdo_q[$];
  logic [21:0] rda_q[$];
  logic [29:0] wr_q[$];

  logic [7:0]  mon_d;
  logic [21:0] mon_a;
  logic [29:0] mon_w;

  cart_mem_arbiter #(.AW(22)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .wr_overrun(wr_overrun),
    .rom_rd(rom_rd), .rom_a(rom_a), .rom_do(rom_do), .rom_valid(rom_valid),
    .cart_mask(cart_mask), .cart_loaded(cart_loaded),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Scoreboard side: every DUT transaction is matched against what the stimulus queued.
  always @(negedge clk_sys) begin
    if (rom_valid) begin
      n_valid++;
      if (rdo_q.size() == 0) check("rom_valid_unexpected", rom_valid, 0);
      else begin
        mon_d = rdo_q.pop_front();
        check("rom_do_data", rom_do, mon_d);
      end
    end
    if (mem_rd) begin
      n_memrd++;
      if (rda_q.size() == 0) check("mem_rd_unexpected", mem_rd, 0);
      else begin
        mon_a = rda_q.pop_front();
        check("mem_rd_addr", mem_addr, mon_a);
      end
    end
    if (mem_we) begin
      n_memwe++;
      if (wr_q.size() == 0) check("mem_we_unexpected", mem_we, 0);
      else begin
        mon_w = wr_q.pop_front();
        check("mem_we_addr_data", {mem_addr, mem_din}, mon_w);
      end
    end
  end

  task automatic do_write(input logic [24:0] a, input logic [7:0] d, input int dly);
    wr_q.push_back({a[21:0], d});
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
    check("wr_latency", mem_we, 1);
    repeat (dly - 1) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [21:0] a, input logic [21:0] ma, input logic [7:0] d,
                         input bit hit);
    int v0;
    v0 = n_valid;
    rdo_q.push_back(d);
    if (!hit) rda_q.push_back(ma);
    rom_a = a; rom_rd = 1'b1;
    tick();
    rom_rd = 1'b0;
    tick();
    if (hit) begin
      check("hit_latency", rom_valid, 1);
    end else begin
      check("miss_latency", mem_rd, 1);
      check("miss_addr", mem_addr, {10'd0, ma});
      tick();
      check("mem_rd_pulse", mem_rd, 0);
      tick();
      mem_dout = d; mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      check("miss_valid", rom_valid, 1);
      check("miss_data", rom_do, d);
    end
    tick();
    check("valid_pulse", rom_valid, 0);
    check("valid_count", n_valid - v0, 1);
  endtask

  initial begin
    int m0;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    rom_rd = 1'b0; rom_a = '0; mem_dout = '0; mem_ready = 1'b0;
    repeat (3) tick();
    check("rst_ioctl_wait", ioctl_wait, 0);
    check("rst_wr_overrun", wr_overrun, 0);
    check("rst_rom_do", rom_do, 0);
    check("rst_rom_valid", rom_valid, 0);
    check("rst_cart_mask", cart_mask, 8'hFF);
    check("rst_cart_loaded", cart_loaded, 0);
    check("rst_mem_bus", {mem_addr, mem_din, mem_we, mem_rd}, 0);
    reset = 1'b0;
    tick();

    // First read miss through SDRAM.
    do_read(22'h000100, 22'h000100, 8'h5A, 1'b0);
    check("mask_after_read", cart_mask, 8'hFF);

    // Cache hit on repeat, then a write forces a miss.
    do_read(22'h000200, 22'h000200, 8'hC3, 1'b0);
    m0 = n_memrd;
    do_read(22'h000200, 22'h000200, 8'hC3, 1'b1);
    check("hit_no_mem_rd", n_memrd - m0, 0);
    do_write(25'h000300, 8'h11, 2);
    do_read(22'h000200, 22'h000200, 8'hC4, 1'b0);

    // 48 KB download (sampled addresses plus the top byte).
    ioctl_download = 1'b1;
    tick(); tick();
    m0 = n_memrd;
    rom_a = 22'h000050; rom_rd = 1'b1;
    tick();
    rom_rd = 1'b0;
    repeat (3) tick();
    check("rd_ignored_in_dl", n_memrd - m0, 0);
    for (int a = 0; a < 32'hC000; a += 32'h400) do_write(25'(a), 8'(a >> 10), 2);
    do_write(25'h00BFFF, 8'hEE, 2);
    ioctl_download = 1'b0;
    repeat (3) tick();
    check("dl48k_mask", cart_mask, 8'h03);
    check("dl48k_loaded", cart_loaded, 1);
    check("dl48k_overrun", wr_overrun, 0);
    do_read(22'h01C005, 22'h00C005, 8'h77, 1'b0);

    // Overrun: second write while first is still pending.
    wr_q.push_back({22'h000010, 8'hAA});
    ioctl_addr = 25'h10; ioctl_dout = 8'hAA; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
    check("ovr_first_we", mem_we, 1);
    ioctl_addr = 25'h20; ioctl_dout = 8'hBB; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    check("ovr_flag", wr_overrun, 1);
    check("ovr_wait_hi", ioctl_wait, 1);
    tick();
    check("ovr_wait_hold", ioctl_wait, 1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    repeat (3) tick();
    check("ovr_wait_lo", ioctl_wait, 0);
    check("ovr_sticky", wr_overrun, 1);

    // Download ends while the last write is still outstanding.
    ioctl_download = 1'b1;
    tick(); tick();
    check("dl_start_clr_ovr", wr_overrun, 0);
    check("dl_start_clr_loaded", cart_loaded, 0);
    do_write(25'h000000, 8'h01, 2);
    wr_q.push_back({22'h012345, 8'h9C});
    ioctl_addr = 25'h012345; ioctl_dout = 8'h9C; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
    check("late_we", mem_we, 1);
    repeat (3) tick();
    check("late_mask_hold", cart_mask, 8'h03);
    check("late_loaded_hold", cart_loaded, 0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    repeat (2) tick();
    check("late_mask", cart_mask, 8'h07);
    check("late_loaded", cart_loaded, 1);

    // Empty download.
    ioctl_download = 1'b1;
    tick(); tick();
    ioctl_download = 1'b0;
    repeat (3) tick();
    check("empty_dl_mask", cart_mask, 8'h00);
    check("empty_dl_loaded", cart_loaded, 1);

    // Reset in the middle of a read, then a stray mem_ready.
    rda_q.push_back(22'h000400);
    rom_a = 22'h000400; rom_rd = 1'b1;
    tick();
    rom_rd = 1'b0;
    tick();
    check("abort_mem_rd", mem_rd, 1);
    m0 = n_valid;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0; mem_dout = 8'hEE; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    check("abort_no_valid", n_valid - m0, 0);
    check("abort_rom_do", rom_do, 0);
    check("abort_mask", cart_mask, 8'hFF);
    check("abort_loaded", cart_loaded, 0);
    check("abort_mem_bus", {mem_addr, mem_din, mem_we, mem_rd}, 0);
    check("abort_wait", ioctl_wait, 0);
    do_read(22'h000500, 22'h000500, 8'h42, 1'b0);

    tick();
    check("sb_rdo_empty", rdo_q.size(), 0);
    check("sb_rda_empty", rda_q.size(), 0);
    check("sb_wr_empty", wr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
